regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: the ALU and the data-memory load path. Memory loads have priority. ALU results queue in a small FIFO, with an anti-starvation override so queued ALU results always drain. The block also drives the per-write condition bit and reports read-after-write hazards for decode.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register index width
NUM_REGS, 7, implemented registers (indices 0..NUM_REGS-1); higher indices are unmapped
FIFO_DEPTH, 2, ALU writeback queue depth (power of 2)
STARVE_LIMIT, 4, cycles a FIFO head may wait before forcing an ALU grant

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_cond  in  1  ALU condition flag for this write
alu_ready  out  1  FIFO can accept; equals !full
mem_valid  in  1  load writeback request
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load accepted this cycle
rs1  in  ADDR_W  decode read index A
rs2  in  ADDR_W  decode read index B
hazard  out  1  rs1 or rs2 has a pending write
rf_reg_write  out  1  write strobe to register file, registered
rf_rd  out  ADDR_W  write index, registered
rf_write_data  out  DATA_W  write data, registered
rf_condition_bit  out  1  condition bit accompanying the write, registered
drop  out  1  one-cycle pulse: an accepted request targeted an unmapped index
idle  out  1  FIFO empty and no write in flight

Behaviour:
- Reset (async, any time) clears the FIFO, starve counter, and cond_q, and sets grant state to GNT_NONE. All outputs go low: rf_* = 0, drop = 0, hazard derives from the empty state. Writes in flight are lost.
- Handshake: a transfer occurs when valid && ready at a posedge. Requesters hold their signals stable while valid && !ready.
- alu_ready = !full, computed from the current occupancy. A pop in the same cycle does not free a slot for a push.
- mem_ready = 1, except in the force cycle: FIFO non-empty && starve_cnt == STARVE_LIMIT makes mem_ready = 0.
- Grant state, registered and re-evaluated every posedge. Priority order:
  - Force: FIFO non-empty && starve_cnt == STARVE_LIMIT → GNT_ALU_FORCED; pop the head.
  - mem_valid && mem_ready → GNT_MEM.
  - FIFO non-empty → GNT_ALU; pop the head.
  - Otherwise → GNT_NONE.
- rf_reg_write = 1 during the cycle after a grant edge, for GNT_MEM, GNT_ALU and GNT_ALU_FORCED.
- Latency: a load commits at the first edge after acceptance (1 cycle). An ALU result is pushed at edge N and commits no earlier than edge N+1. rf_* are stable for the following negedge, where the register file writes.
- starve_cnt: cleared when the FIFO is empty or on any pop. Otherwise it increments once per cycle, saturating at STARVE_LIMIT.
- Condition bit:
  - ALU commit: rf_condition_bit = the entry's alu_cond, and cond_q takes that value.
  - Load commit: rf_condition_bit = cond_q; cond_q is unchanged.
- Unmapped index (rd >= NUM_REGS):
  - The request is accepted but neither pushed nor committed.
  - drop pulses high for one cycle after acceptance.
  - If both requesters drop in the same cycle, drop is still a single pulse.
- Unmapped index and the same-cycle grant: a dropped load still counts as mem accepted, and the grant that cycle is GNT_NONE. The FIFO head is not popped.
- hazard (combinational): 1 if rs1 or rs2 matches the rd of any valid FIFO entry, or matches rf_rd while rf_reg_write = 1.
- idle = FIFO empty && !rf_reg_write.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses an extra bit to distinguish full from empty.
- The same rd pending in both paths is legal. Commit order defines the final value.

Decomposition:
- Package regfile_pkg holds DATA_W/ADDR_W/NUM_REGS constants and the grant_t enum (GNT_NONE, GNT_MEM, GNT_ALU, GNT_ALU_FORCED).
- The package also holds the wb_req_t struct {rd, data, cond}.
- Sub-module wb_fifo: a parameterised synchronous FIFO. It exposes push, pop, full, empty, head, and a flattened entries/valid vector for the hazard compare.

Test Plan:
- ALU only: alu_valid with rd=2, data=8'h3C, cond=1 → rf_reg_write high 2 cycles later, rf_rd=2, rf_write_data=3C, rf_condition_bit=1. idle returns to 1 the next cycle.
- Collision: load (rd=1, 8'hAA) and ALU (rd=3, 8'h55) in the same cycle → load commits first; ALU commits next cycle. Load rf_condition_bit equals the previous ALU cond (0 after reset).
- Starvation: mem_valid held high continuously with one ALU entry queued → mem_ready drops for exactly one cycle after 4 waiting cycles, and the ALU entry commits with GNT_ALU_FORCED.
- Full: three back-to-back ALU requests under mem traffic → alu_ready=0 after two accepts. The third request is held and accepted only after a pop, one cycle later.
- Unmapped index: alu_rd=7 → accepted, drop pulses once, no rf_reg_write. hazard asserts for rs1=3 while an rd=3 write is queued, and clears after its commit cycle.
- Reset mid-operation: assert rst with two queued entries → rf_reg_write=0 immediately, FIFO empty, and no writes after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
// Holds the register geometry, grant encoding and the queued writeback record.
package regfile_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 7;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_ALU,
    GNT_ALU_FORCED
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              cond;
  } wb_req_t;

  // Indices at or above NUM_REGS have no backing register.
  function automatic logic is_mapped(input logic [ADDR_W-1:0] rd);
    return 32'(rd) < NUM_REGS;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback records (Depth a power of two, at least 2).
// Exposes every slot's rd plus a per-slot valid vector for hazard detection.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  wb_req_t                 push_data_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output wb_req_t                 head_o,
  output logic [Depth*ADDR_W-1:0] rds_o,
  output logic [Depth-1:0]        valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_req_t       mem_q [Depth];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0] count;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == (PtrW + 1)'(Depth));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
  end

  always_comb begin
    rds_o   = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      rds_o[i*ADDR_W +: ADDR_W] = mem_q[i].rd;
      valid_o[i] = ({1'b0, PtrW'(i) - rd_ptr_q[PtrW-1:0]} < count);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between loads and queued ALU results.
// Loads win unless the ALU queue head has waited STARVE_LIMIT cycles.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_cond,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_condition_bit,
  output logic              drop,
  output logic              idle
);

  localparam int unsigned     CntW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  grant_t                       grant_q, grant_d;
  logic [CntW-1:0]              starve_q;
  logic                         cond_q;
  logic                         fifo_full, fifo_empty, fifo_pop;
  logic                         force_alu, mem_acc, mem_drop, alu_acc, alu_push, alu_drop;
  wb_req_t                      fifo_head, alu_req;
  logic [FIFO_DEPTH*ADDR_W-1:0] fifo_rds;
  logic [FIFO_DEPTH-1:0]        fifo_valid;

  assign alu_req = '{rd: alu_rd, data: alu_data, cond: alu_cond};

  wb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (alu_push),
    .push_data_i (alu_req),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .rds_o       (fifo_rds),
    .valid_o     (fifo_valid)
  );

  always_comb begin
    force_alu = !fifo_empty && (starve_q == StarveMax);
    mem_ready = !force_alu;
    alu_ready = !fifo_full;
    mem_acc   = mem_valid && mem_ready;
    alu_acc   = alu_valid && alu_ready;
    mem_drop  = mem_acc && !is_mapped(mem_rd);
    alu_drop  = alu_acc && !is_mapped(alu_rd);
    alu_push  = alu_acc && is_mapped(alu_rd);

    grant_d  = GNT_NONE;
    fifo_pop = 1'b0;
    if (force_alu) begin
      grant_d  = GNT_ALU_FORCED;
      fifo_pop = 1'b1;
    end else if (mem_acc) begin
      // A dropped load still consumes the slot, so the ALU head waits.
      grant_d = mem_drop ? GNT_NONE : GNT_MEM;
    end else if (!fifo_empty) begin
      grant_d  = GNT_ALU;
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q          <= GNT_NONE;
      starve_q         <= '0;
      cond_q           <= 1'b0;
      rf_rd            <= '0;
      rf_write_data    <= '0;
      rf_condition_bit <= 1'b0;
      drop             <= 1'b0;
    end else begin
      grant_q <= grant_d;
      drop    <= mem_drop || alu_drop;

      if (fifo_empty || fifo_pop) begin
        starve_q <= '0;
      end else if (starve_q != StarveMax) begin
        starve_q <= starve_q + 1'b1;
      end

      unique case (grant_d)
        GNT_MEM: begin
          rf_rd            <= mem_rd;
          rf_write_data    <= mem_data;
          rf_condition_bit <= cond_q;
        end
        GNT_ALU, GNT_ALU_FORCED: begin
          rf_rd            <= fifo_head.rd;
          rf_write_data    <= fifo_head.data;
          rf_condition_bit <= fifo_head.cond;
          cond_q           <= fifo_head.cond;
        end
        default: begin
          rf_rd            <= '0;
          rf_write_data    <= '0;
          rf_condition_bit <= 1'b0;
        end
      endcase
    end
  end

  assign rf_reg_write = (grant_q != GNT_NONE);
  assign idle         = fifo_empty && !rf_reg_write;

  always_comb begin
    hazard = rf_reg_write && ((rf_rd == rs1) || (rf_rd == rs2));
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i] && ((fifo_rds[i*ADDR_W +: ADDR_W] == rs1) ||
                            (fifo_rds[i*ADDR_W +: ADDR_W] == rs2))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule
